encoder_16line_4line_arb: RTL and testbench

//  Registered 16-line to 4-line request encoder. Inverse of the control-word line decoder.
//  - Captures up to 16 one-hot/multi-hot request lines into a sticky pending register.
//  - Presents one request at a time as a 4-bit index with valid/ack handshake.
//  - Sits between peripheral/interrupt request lines and the SAP control sequencer.

---
 rtl/encoder_16line_4line_arb.sv | 153 +++++++++++++++
 tb/tb_encoder_16line_4line_arb.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_16line_4line_arb.sv
// encoder_16line_4line_arb
//   Registered 16-line to 4-line request encoder with a valid/ack handshake.
//   Request lines are folded into a sticky pending register.
//   One pending line at a time is presented as a 4-bit code until the consumer
//   acknowledges it. When TIMEOUT is non-zero, the grant is withdrawn after that
//   many cycles without an acknowledge.
//
//   Optional feature macro: ENCODER_ROUND_ROBIN_EN
//     defined   : rotating priority, searching upward from the last granted index + 1
//     undefined : fixed priority, the lowest set index wins
module encoder_16line_4line_arb #(
  parameter int TIMEOUT = 0  // grant lifetime in cycles without ack; 0 = never withdraw (0..255)
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [15:0] req,
  input  logic        ack,
  output logic [3:0]  code,
  output logic        valid,
  output logic        timeout,
  output logic [15:0] pending
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Timer value on which an unacknowledged grant expires.
  localparam logic [7:0] TIMER_LAST = 8'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit         TIMEOUT_ON = (TIMEOUT != 0);

  state_t      state, state_next;
  logic [7:0]  timer, timer_next;
  logic [3:0]  code_next;
  logic        valid_next;
  logic        timeout_next;
  logic [15:0] pending_next;
  logic [15:0] clr_mask;
  logic [3:0]  sel_code;

`ifdef ENCODER_ROUND_ROBIN_EN
  logic [3:0]  last, last_next;

  // Return the first set bit found when searching upward from start, wrapping 15 -> 0.
  function automatic logic [3:0] sel_rr(input logic [15:0] p, input logic [3:0] start);
    logic [3:0] idx;
    logic       found;
    sel_rr = start;
    found  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      idx = start + 4'(i);
      if (!found && p[idx]) begin
        sel_rr = idx;
        found  = 1'b1;
      end
    end
  endfunction
`else
  // Return the lowest set index. Bit 0 has the highest priority.
  function automatic logic [3:0] sel_fixed(input logic [15:0] p);
    sel_fixed = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (p[i]) sel_fixed = 4'(i);
    end
  endfunction
`endif

  // Choose the next line to grant from the registered pending set, not from the raw request lines.
  always_comb begin
`ifdef ENCODER_ROUND_ROBIN_EN
    sel_code = sel_rr(pending, last + 4'd1);
`else
    sel_code = sel_fixed(pending);
`endif
  end

  // Compute the next handshake state, the grant outputs and the pending-bit update.
  always_comb begin
    // NOTE: every signal assigned here first receives a default (hold or idle value), so no path can infer a latch.
    state_next   = state;
    code_next    = code;
    valid_next   = valid;
    timeout_next = 1'b0;
    timer_next   = timer;
    clr_mask     = '0;
`ifdef ENCODER_ROUND_ROBIN_EN
    last_next    = last;
`endif

    unique case (state)
      IDLE: begin
        if (|pending) begin
          code_next  = sel_code;
          valid_next = 1'b1;
          timer_next = 8'd0;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (ack) begin
          clr_mask   = 16'd1 << code;
          valid_next = 1'b0;
`ifdef ENCODER_ROUND_ROBIN_EN
          last_next  = code;
`endif
          state_next = IDLE;
        end else if (TIMEOUT_ON && (timer == TIMER_LAST)) begin
          // Withdraw the grant but keep the line pending, so it is granted again later.
          valid_next   = 1'b0;
          timeout_next = 1'b1;
`ifdef ENCODER_ROUND_ROBIN_EN
          last_next    = code;
`endif
          state_next   = IDLE;
        end else if (timer != 8'hFF) begin
          timer_next = timer + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    // A request that arrives on the same edge as its acknowledge keeps the bit pending.
    pending_next = (pending & ~clr_mask) | req;
  end

  // State and output registers. Asynchronous clear returns to an idle state with no requests.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      pending <= '0;
      code    <= 4'd0;
      valid   <= 1'b0;
      timeout <= 1'b0;
      timer   <= 8'd0;
`ifdef ENCODER_ROUND_ROBIN_EN
      last    <= 4'd15;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples the values from before the edge.
      state   <= state_next;
      pending <= pending_next;
      code    <= code_next;
      valid   <= valid_next;
      timeout <= timeout_next;
      timer   <= timer_next;
`ifdef ENCODER_ROUND_ROBIN_EN
      last    <= last_next;
`endif
    end
  end

endmodule

// File: tb/tb_encoder_16line_4line_arb.sv
// Testbench for encoder_16line_4line_arb.
// The default-parameter instance (u_dut, no timeout) runs the handshake and priority scenarios.
// A second instance (u_dut_to, TIMEOUT=4) runs the grant-withdrawal scenario.
// Expected grant codes are pushed to a scoreboard queue when stimulus is driven.
// Each code is popped and compared when the DUT raises valid.
module tb_encoder_16line_4line_arb;

  logic        clk;
  logic        clr;
  logic [15:0] req;
  logic        ack;
  logic [3:0]  code;
  logic        valid;
  logic        timeout;
  logic [15:0] pending;

  logic [15:0] req_t;
  logic        ack_t;
  logic [3:0]  code_t;
  logic        valid_t;
  logic        timeout_t;
  logic [15:0] pending_t;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  encoder_16line_4line_arb u_dut (
    .clk     (clk),
    .clr     (clr),
    .req     (req),
    .ack     (ack),
    .code    (code),
    .valid   (valid),
    .timeout (timeout),
    .pending (pending)
  );

  encoder_16line_4line_arb #(.TIMEOUT(4)) u_dut_to (
    .clk     (clk),
    .clr     (clr),
    .req     (req_t),
    .ack     (ack_t),
    .code    (code_t),
    .valid   (valid_t),
    .timeout (timeout_t),
    .pending (pending_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Inputs are driven and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    clr   = 1'b1;
    req   = '0;
    ack   = 1'b0;
    req_t = '0;
    ack_t = 1'b0;
    step();
    clr = 1'b0;
    step();
  endtask

  // Wait at most max_wait cycles for valid, then compare the code with the scoreboard head.
  // If do_ack is set, acknowledge the grant and confirm that valid drops.
  task automatic serve_grant(input string tag, input int max_wait, input bit do_ack);
    int n;
    n = 0;
    while (!valid && n < max_wait) begin
      step();
      n++;
    end
    check({tag, "_valid"}, 32'(valid), 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected"}, 32'(code), 32'hFFFF_FFFF);
    end else begin
      check({tag, "_code"}, 32'(code), 32'(exp_q.pop_front()));
    end
    if (do_ack) begin
      ack = 1'b1;
      step();
      ack = 1'b0;
      check({tag, "_gap"}, 32'(valid), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr   = 1'b1;
    req   = '0;
    ack   = 1'b0;
    req_t = '0;
    ack_t = 1'b0;
    step();
    step();
    // Reset state, with clr still held high while the clock runs.
    check("rst_code",    32'(code),    32'd0);
    check("rst_valid",   32'(valid),   32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    clr = 1'b0;
    step();

    // An ack while idle with no requests is ignored, and the outputs do not change.
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    check("idle_ack_valid",   32'(valid),   32'd0);
    check("idle_ack_pending", 32'(pending), 32'd0);

    // Test 1: a single request, two-edge latency, then acknowledge.
    exp_q.push_back(4);
    req = 16'h0010;
    step();
    req = 16'h0000;
    check("t1_pending_k",  32'(pending), 32'h0010);
    check("t1_valid_k",    32'(valid),   32'd0);
    step();
    serve_grant("t1", 0, 1'b1);
    check("t1_pending_clr", 32'(pending), 32'h0000);

    // Test 2: a multi-hot request, one grant per line with a one-cycle valid gap.
    do_reset();
    exp_q.push_back(0);
    exp_q.push_back(8);
    exp_q.push_back(15);
    req = 16'h8101;
    step();
    req = 16'h0000;
    step();
    serve_grant("t2_g0", 0, 1'b1);
    serve_grant("t2_g1", 1, 1'b1);
    serve_grant("t2_g2", 1, 1'b1);
    check("t2_pending_end", 32'(pending), 32'h0000);

    // Test 3: requests held high, every grant acknowledged.
    do_reset();
`ifdef ENCODER_ROUND_ROBIN_EN
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(0);
    exp_q.push_back(1);
`else
    exp_q.push_back(0);
    exp_q.push_back(0);
    exp_q.push_back(0);
    exp_q.push_back(0);
`endif
    req = 16'h0003;
    step();
    step();
    serve_grant("t3_g0", 0, 1'b1);
    serve_grant("t3_g1", 1, 1'b1);
    serve_grant("t3_g2", 1, 1'b1);
    serve_grant("t3_g3", 1, 1'b1);
    req = 16'h0000;

    // Test 4: TIMEOUT=4 instance withdraws an unacknowledged grant. The TIMEOUT=0 instance holds its grant.
    do_reset();
    exp_q.push_back(9);
    req_t = 16'h0200;
    req   = 16'h0200;
    step();
    req_t = 16'h0000;
    req   = 16'h0000;
    step();
    check("t4_code", 32'(code_t), 32'(exp_q.pop_front()));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_valid_c%0d", i),   32'(valid_t),   32'd1);
      check($sformatf("t4_timeout_c%0d", i), 32'(timeout_t), 32'd0);
      step();
    end
    check("t4_withdraw_valid", 32'(valid_t),   32'd0);
    check("t4_timeout_pulse",  32'(timeout_t), 32'd1);
    check("t4_pending_kept",   32'(pending_t), 32'h0200);
    step();
    exp_q.push_back(9);
    check("t4_pulse_end",    32'(timeout_t), 32'd0);
    check("t4_regrant_valid", 32'(valid_t),  32'd1);
    check("t4_regrant_code", 32'(code_t),    32'(exp_q.pop_front()));
    for (int i = 0; i < 4; i++) step();
    check("t4_notimeout_valid",   32'(valid),   32'd1);
    check("t4_notimeout_timeout", 32'(timeout), 32'd0);
    check("t4_notimeout_code",    32'(code),    32'd9);

    // Test 5: the same line is requested again on its acknowledge edge.
    do_reset();
    exp_q.push_back(3);
    exp_q.push_back(3);
    req = 16'h0008;
    step();
    req = 16'h0000;
    step();
    serve_grant("t5_first", 0, 1'b0);
    ack = 1'b1;
    req = 16'h0008;
    step();
    ack = 1'b0;
    req = 16'h0000;
    check("t5_gap_valid",   32'(valid),   32'd0);
    check("t5_pending_kept", 32'(pending), 32'h0008);
    serve_grant("t5_regrant", 1, 1'b1);
    check("t5_pending_end", 32'(pending), 32'h0000);

    // Test 6: clr during an active grant with every line pending.
    do_reset();
    exp_q.push_back(0);
    req = 16'hFFFF;
    step();
    req = 16'h0000;
    step();
    serve_grant("t6_grant", 0, 1'b0);
    check("t6_pending_full", 32'(pending), 32'hFFFF);
    #2 clr = 1'b1;
    #1;
    check("t6_async_valid",   32'(valid),   32'd0);
    check("t6_async_code",    32'(code),    32'd0);
    check("t6_async_pending", 32'(pending), 32'd0);
    check("t6_async_timeout", 32'(timeout), 32'd0);
    step();
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t6_no_grant_%0d", i), 32'(valid), 32'd0);
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
